// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: icache, dcache and uncached requesters
// share one downstream master port, with a no-ack watchdog.
module wb_rr_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m0_icache_wbd_dat_i,
    input  logic [31:0] m0_icache_wbd_adr_i,
    input  logic [3:0]  m0_icache_wbd_sel_i,
    input  logic        m0_icache_wbd_we_i,
    input  logic        m0_icache_wbd_cyc_i,
    input  logic        m0_icache_wbd_stb_i,
    output logic [31:0] m0_icache_wbd_dat_o,
    output logic        m0_icache_wbd_ack_o,
    output logic        m0_icache_wbd_err_o,
    input  logic [31:0] m1_dcache_wbd_dat_i,
    input  logic [31:0] m1_dcache_wbd_adr_i,
    input  logic [3:0]  m1_dcache_wbd_sel_i,
    input  logic        m1_dcache_wbd_we_i,
    input  logic        m1_dcache_wbd_cyc_i,
    input  logic        m1_dcache_wbd_stb_i,
    output logic [31:0] m1_dcache_wbd_dat_o,
    output logic        m1_dcache_wbd_ack_o,
    output logic        m1_dcache_wbd_err_o,
    input  logic [31:0] m2_others_wbd_dat_i,
    input  logic [31:0] m2_others_wbd_adr_i,
    input  logic [3:0]  m2_others_wbd_sel_i,
    input  logic        m2_others_wbd_we_i,
    input  logic        m2_others_wbd_cyc_i,
    input  logic        m2_others_wbd_stb_i,
    output logic [31:0] m2_others_wbd_dat_o,
    output logic        m2_others_wbd_ack_o,
    output logic        m2_others_wbd_err_o,
    output logic [31:0] m2_wbd_dat_o,
    output logic [31:0] m2_wbd_adr_o,
    output logic [3:0]  m2_wbd_sel_o,
    output logic        m2_wbd_we_o,
    output logic        m2_wbd_cyc_o,
    output logic        m2_wbd_stb_o,
    output logic [9:0]  m2_wbd_bl_o,
    output logic        m2_wbd_bry_o,
    input  logic [31:0] m2_wbd_dat_i,
    input  logic        m2_wbd_ack_i,
    output logic [2:0]  grant_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_ABORT,
        S_WAIT
    } state_t;

    localparam bit          LP_WD_EN = (TIMEOUT != 0);
    localparam logic [7:0]  LP_LAST  = 8'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_owner;
    logic [1:0]  w_owner_nxt;
    logic [1:0]  r_ptr;
    logic [1:0]  w_ptr_nxt;
    logic [7:0]  r_wd;

    logic [2:0]  w_pend;
    logic [1:0]  w_sel;
    logic [31:0] w_adr;
    logic [31:0] w_dat;
    logic [3:0]  w_be;
    logic        w_we;
    logic        w_ocyc;
    logic        w_ostb;
    logic        w_busy;
    logic        w_expire;
    logic [2:0]  w_grant;
    logic [2:0]  w_ack;
    logic [2:0]  w_err;

    function automatic logic [1:0] f_add3(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    assign w_pend = {m2_others_wbd_cyc_i & m2_others_wbd_stb_i,
                     m1_dcache_wbd_cyc_i & m1_dcache_wbd_stb_i,
                     m0_icache_wbd_cyc_i & m0_icache_wbd_stb_i};

    // Nearest pending requester at or after the pointer wins
    always_comb begin
        logic [1:0] v_cand;
        w_sel = r_ptr;
        for (int k = 2; k >= 0; k--) begin
            v_cand = f_add3(r_ptr, 2'(k));
            if (w_pend[v_cand]) w_sel = v_cand;
        end
    end

    always_comb begin
        w_adr  = '0;
        w_dat  = '0;
        w_be   = '0;
        w_we   = 1'b0;
        w_ocyc = 1'b0;
        w_ostb = 1'b0;
        case (r_owner)
            2'd0: begin
                w_adr  = m0_icache_wbd_adr_i;
                w_dat  = m0_icache_wbd_dat_i;
                w_be   = m0_icache_wbd_sel_i;
                w_we   = m0_icache_wbd_we_i;
                w_ocyc = m0_icache_wbd_cyc_i;
                w_ostb = m0_icache_wbd_stb_i;
            end
            2'd1: begin
                w_adr  = m1_dcache_wbd_adr_i;
                w_dat  = m1_dcache_wbd_dat_i;
                w_be   = m1_dcache_wbd_sel_i;
                w_we   = m1_dcache_wbd_we_i;
                w_ocyc = m1_dcache_wbd_cyc_i;
                w_ostb = m1_dcache_wbd_stb_i;
            end
            default: begin
                w_adr  = m2_others_wbd_adr_i;
                w_dat  = m2_others_wbd_dat_i;
                w_be   = m2_others_wbd_sel_i;
                w_we   = m2_others_wbd_we_i;
                w_ocyc = m2_others_wbd_cyc_i;
                w_ostb = m2_others_wbd_stb_i;
            end
        endcase
    end

    assign w_busy       = (r_state == S_BUSY);
    assign m2_wbd_cyc_o = w_busy & w_ocyc;
    assign m2_wbd_stb_o = w_busy & w_ocyc & w_ostb;
    assign m2_wbd_adr_o = w_busy ? w_adr : '0;
    assign m2_wbd_dat_o = w_busy ? w_dat : '0;
    assign m2_wbd_sel_o = w_busy ? w_be : '0;
    assign m2_wbd_we_o  = w_busy & w_we;
    assign m2_wbd_bl_o  = {9'd0, m2_wbd_stb_o};
    assign m2_wbd_bry_o = m2_wbd_stb_o;

    // An ack in the expiry cycle wins over the watchdog
    assign w_expire = LP_WD_EN && m2_wbd_stb_o && !m2_wbd_ack_i && (r_wd == LP_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_owner <= 2'd0;
            r_ptr   <= 2'd0;
            r_wd    <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            if (!w_busy || !m2_wbd_stb_o || m2_wbd_ack_i) r_wd <= 8'd0;
            else                                          r_wd <= r_wd + 8'd1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        unique case (r_state)
            S_IDLE: begin
                if (|w_pend) begin
                    w_state_nxt = S_BUSY;
                    w_owner_nxt = w_sel;
                end
            end
            S_BUSY: begin
                if (!w_ocyc) begin
                    w_state_nxt = S_IDLE;
                    w_ptr_nxt   = f_add3(r_owner, 2'd1);
                end else if (w_expire) begin
                    w_state_nxt = S_ABORT;
                end
            end
            S_ABORT: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (!w_ocyc) begin
                    w_state_nxt = S_IDLE;
                    w_ptr_nxt   = f_add3(r_owner, 2'd1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_grant = 3'd0;
        w_ack   = 3'd0;
        w_err   = 3'd0;
        if (r_state != S_IDLE)  w_grant = 3'b001 << r_owner;
        if (w_busy)             w_ack   = w_grant & {3{m2_wbd_ack_i}};
        if (r_state == S_ABORT) w_err   = w_grant;
    end

    assign grant_o   = w_grant;
    assign timeout_o = (r_state == S_ABORT);

    assign m0_icache_wbd_dat_o = m2_wbd_dat_i;
    assign m1_dcache_wbd_dat_o = m2_wbd_dat_i;
    assign m2_others_wbd_dat_o = m2_wbd_dat_i;
    assign m0_icache_wbd_ack_o = w_ack[0];
    assign m1_dcache_wbd_ack_o = w_ack[1];
    assign m2_others_wbd_ack_o = w_ack[2];
    assign m0_icache_wbd_err_o = w_err[0];
    assign m1_dcache_wbd_err_o = w_err[1];
    assign m2_others_wbd_err_o = w_err[2];

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Scoreboard bench for wb_rr_arbiter: three random requesters, a random
// latency slave, and a monitor checking grant order and every response.
module tb_wb_rr_arbiter;

    localparam int T   = 8;
    localparam int NTX = 20;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
    } beat_t;

    typedef struct {
        logic        err;
        logic [31:0] dat;
        int          cyc;
    } resp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dat_i [3];
    logic [31:0] adr_i [3];
    logic [3:0]  sel_i [3];
    logic        we_i  [3];
    logic        cyc_i [3];
    logic        stb_i [3];
    logic [31:0] dat_o [3];
    logic        ack_o [3];
    logic        err_o [3];
    logic [31:0] m_dat_o, m_adr_o, s_dat_i;
    logic [3:0]  m_sel_o;
    logic        m_we_o, m_cyc_o, m_stb_o, m_bry_o, s_ack_i;
    logic [9:0]  m_bl_o;
    logic [2:0]  grant;
    logic        tmo;

    int    tests = 0;
    int    fails = 0;
    int    cyc_n = 0;
    bit    done  = 0;
    beat_t cur [3];
    resp_t rq [$];
    int    own_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    wb_rr_arbiter #(.TIMEOUT(T)) dut (
        .clk(clk), .reset(reset),
        .m0_icache_wbd_dat_i(dat_i[0]), .m0_icache_wbd_adr_i(adr_i[0]),
        .m0_icache_wbd_sel_i(sel_i[0]), .m0_icache_wbd_we_i(we_i[0]),
        .m0_icache_wbd_cyc_i(cyc_i[0]), .m0_icache_wbd_stb_i(stb_i[0]),
        .m0_icache_wbd_dat_o(dat_o[0]), .m0_icache_wbd_ack_o(ack_o[0]),
        .m0_icache_wbd_err_o(err_o[0]),
        .m1_dcache_wbd_dat_i(dat_i[1]), .m1_dcache_wbd_adr_i(adr_i[1]),
        .m1_dcache_wbd_sel_i(sel_i[1]), .m1_dcache_wbd_we_i(we_i[1]),
        .m1_dcache_wbd_cyc_i(cyc_i[1]), .m1_dcache_wbd_stb_i(stb_i[1]),
        .m1_dcache_wbd_dat_o(dat_o[1]), .m1_dcache_wbd_ack_o(ack_o[1]),
        .m1_dcache_wbd_err_o(err_o[1]),
        .m2_others_wbd_dat_i(dat_i[2]), .m2_others_wbd_adr_i(adr_i[2]),
        .m2_others_wbd_sel_i(sel_i[2]), .m2_others_wbd_we_i(we_i[2]),
        .m2_others_wbd_cyc_i(cyc_i[2]), .m2_others_wbd_stb_i(stb_i[2]),
        .m2_others_wbd_dat_o(dat_o[2]), .m2_others_wbd_ack_o(ack_o[2]),
        .m2_others_wbd_err_o(err_o[2]),
        .m2_wbd_dat_o(m_dat_o), .m2_wbd_adr_o(m_adr_o), .m2_wbd_sel_o(m_sel_o),
        .m2_wbd_we_o(m_we_o), .m2_wbd_cyc_o(m_cyc_o), .m2_wbd_stb_o(m_stb_o),
        .m2_wbd_bl_o(m_bl_o), .m2_wbd_bry_o(m_bry_o),
        .m2_wbd_dat_i(s_dat_i), .m2_wbd_ack_i(s_ack_i),
        .grant_o(grant), .timeout_o(tmo)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int n, input bit on, input logic [31:0] a);
        cyc_i[n] = on;
        stb_i[n] = on;
        adr_i[n] = a;
        we_i[n]  = 1'b0;
        sel_i[n] = 4'hf;
    endtask

    task automatic master(input int n);
        int nb, w, gap;
        bit ga, ge;
        for (int t = 0; t < NTX; t++) begin
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
                cur[n].adr = $urandom;
                cur[n].dat = $urandom;
                cur[n].sel = 4'($urandom);
                cur[n].we  = 1'($urandom);
                adr_i[n] = cur[n].adr;
                dat_i[n] = cur[n].dat;
                sel_i[n] = cur[n].sel;
                we_i[n]  = cur[n].we;
                cyc_i[n] = 1'b1;
                stb_i[n] = 1'b1;
                w = 0;
                do begin
                    @(negedge clk);
                    w++;
                    ga = ack_o[n];
                    ge = err_o[n];
                end while (!ga && !ge && w < 400);
                if (!ga && !ge) begin
                    chk("master_wait", 32'(n), 32'hffff_ffff);
                    cyc_i[n] = 1'b0;
                    stb_i[n] = 1'b0;
                    return;
                end
                tick();
                if (ge) break;
            end
            cyc_i[n] = 1'b0;
            stb_i[n] = 1'b0;
            gap = $urandom_range(1, 2);
            repeat (gap) tick();
        end
    endtask

    // Slave: random latency 0..9 per beat; >= T means the watchdog must fire
    // and the ack that still arrives late must be swallowed.
    task automatic slave();
        bit    act = 0;
        int    cnt = 0;
        int    lat = 0;
        resp_t r;
        while (!done) begin
            @(posedge clk);
            #2;
            if (!act && m_stb_o) begin
                act     = 1;
                cnt     = 0;
                lat     = $urandom_range(0, 9);
                s_dat_i = $urandom;
                r.err   = (lat >= T);
                r.dat   = s_dat_i;
                r.cyc   = cyc_n + ((lat >= T) ? T : lat);
                rq.push_back(r);
            end
            s_ack_i = act && (cnt == lat);
            if (act) begin
                if (cnt == lat) act = 0;
                cnt++;
            end
        end
        s_ack_i = 1'b0;
    endtask

    task automatic monitor();
        logic [2:0] pg = 3'd0;
        logic [2:0] av, ev, eg;
        int         own = 0;
        resp_t      r;
        while (!done) begin
            @(negedge clk);
            av = {ack_o[2], ack_o[1], ack_o[0]};
            ev = {err_o[2], err_o[1], err_o[0]};
            if (grant != 3'd0 && pg == 3'd0) begin
                if (own_q.size() == 0) chk("grant_extra", 32'(grant), 32'd0);
                else begin
                    own = own_q.pop_front();
                    eg  = 3'b001 << own;
                    chk("grant_order", 32'(grant), 32'(eg));
                end
            end else if (grant != 3'd0 && grant != pg) begin
                chk("handover_idle", 32'(pg), 32'd0);
            end
            pg = grant;
            chk("timeout_vs_err", 32'(tmo), 32'(|ev));
            if ((av | ev) != 3'd0) begin
                eg = 3'b001 << own;
                chk("resp_owner", 32'(av | ev), 32'(eg));
                if (rq.size() == 0) chk("resp_extra", 32'(av | ev), 32'd0);
                else begin
                    r = rq.pop_front();
                    chk("resp_err", 32'(|ev), 32'(r.err));
                    chk("resp_cycle", 32'(cyc_n), 32'(r.cyc));
                    if (!r.err) begin
                        chk("rd_data", dat_o[own], r.dat);
                        chk("ds_adr", m_adr_o, cur[own].adr);
                        chk("ds_we", 32'(m_we_o), 32'(cur[own].we));
                        chk("ds_sel", 32'(m_sel_o), 32'(cur[own].sel));
                        if (cur[own].we) chk("ds_wdat", m_dat_o, cur[own].dat);
                    end else begin
                        chk("abort_cyc", 32'(m_cyc_o), 32'd0);
                    end
                end
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        s_ack_i = 1'b0;
        s_dat_i = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            req(i, 1'b0, 32'd0);
            dat_i[i] = 32'd0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_cyc", 32'(m_cyc_o), 32'd0);
        chk("rst_stb", 32'(m_stb_o), 32'd0);
        chk("rst_adr", m_adr_o, 32'd0);
        chk("rst_bl", 32'(m_bl_o), 32'd0);
        chk("rst_bry", 32'(m_bry_o), 32'd0);
        chk("rst_tmo", 32'(tmo), 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("rst_ack", 32'(ack_o[i]), 32'd0);
            chk("rst_err", 32'(err_o[i]), 32'd0);
            chk("rst_dat_pass", dat_o[i], 32'h1234_5678);
        end
        tick();
        reset = 1'b0;

        // dcache read, slave acks three cycles after the request
        tick();
        req(1, 1'b1, 32'h1000);
        @(negedge clk);
        chk("rd_idle_grant", 32'(grant), 32'd0);
        tick();
        @(negedge clk);
        chk("rd_grant", 32'(grant), 32'b010);
        chk("rd_adr", m_adr_o, 32'h1000);
        chk("rd_stb", 32'(m_stb_o), 32'd1);
        chk("rd_bl", 32'(m_bl_o), 32'd1);
        tick();
        @(negedge clk);
        chk("rd_no_ack", 32'(ack_o[1]), 32'd0);
        tick();
        #1;
        s_ack_i = 1'b1;
        s_dat_i = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("rd_ack", 32'(ack_o[1]), 32'd1);
        chk("rd_dat", dat_o[1], 32'hDEAD_BEEF);
        chk("rd_ack0", 32'(ack_o[0]), 32'd0);
        chk("rd_ack2", 32'(ack_o[2]), 32'd0);
        tick();
        req(1, 1'b0, 32'd0);
        #1;
        s_ack_i = 1'b0;
        @(negedge clk);
        chk("rd_release_cyc", 32'(m_cyc_o), 32'd0);
        tick();
        @(negedge clk);
        chk("rd_idle_after", 32'(grant), 32'd0);

        // Random saturated phase: all three always pending, so ownership
        // must rotate 0,1,2,... whatever the beat counts and latencies.
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3 * NTX; i++) own_q.push_back(i % 3);
        fork
            begin
                fork
                    master(0);
                    master(1);
                    master(2);
                join
                repeat (12) tick();
                done = 1;
            end
            slave();
            monitor();
        join
        chk("own_q_drained", 32'(own_q.size()), 32'd0);
        chk("rq_drained", 32'(rq.size()), 32'd0);

        // Reset while dcache owns the bus; m0 must win the next contention
        tick();
        req(1, 1'b1, 32'h2000);
        tick();
        @(negedge clk);
        chk("mid_grant", 32'(grant), 32'b010);
        tick();
        reset = 1'b1;
        req(0, 1'b1, 32'h3000);
        req(2, 1'b1, 32'h4000);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_grant", 32'(grant), 32'd0);
        chk("mid_rst_cyc", 32'(m_cyc_o), 32'd0);
        chk("mid_rst_adr", m_adr_o, 32'd0);
        tick();
        @(negedge clk);
        chk("mid_rst_m0_wins", 32'(grant), 32'b001);
        chk("mid_rst_adr_m0", m_adr_o, 32'h3000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
